// File: rtl/gost_core_arbiter.sv
// gost_core_arbiter: shares a single GOST 28147-89 cipher core between NREQ
// requesters. A round-robin grant picks one request, the block is loaded into
// the core, the fixed-length core run is timed with a counter, and the core
// output is returned on a tagged valid/ready response channel. Only one block
// is in flight at a time.
module gost_core_arbiter #(
  parameter int NREQ     = 2,
  parameter int IDW      = 1,
  parameter int CORE_LAT = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_mode,
  input  logic [64*NREQ-1:0] req_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [63:0]        rsp_data,
  output logic               core_load,
  output logic               core_mode,
  output logic [63:0]        core_pdata,
  input  logic               core_done,
  input  logic [63:0]        core_cdata,
  output logic               busy,
  output logic               err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  gid_q, gid_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic [63:0]     pdata_q, pdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [63:0]     rsp_data_q, rsp_data_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] req_rot;
  logic            grant_found;
  logic [IDW:0]    grant_off;
  logic [IDW:0]    grant_sum;
  logic [IDW-1:0]  grant_idx;
  logic [63:0]     grant_data;
  logic            grant_mode;

  // Round-robin grant: rotate the valid vector so the slot after the last
  // grant sits at bit 0, take the lowest set bit, then map it back to an index.
  always_comb begin
    req_rot     = NREQ'({req_valid, req_valid} >> ({1'b0, last_q} + (IDW+1)'(1)));
    grant_found = 1'b0;
    grant_off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        grant_found = 1'b1;
        grant_off   = (IDW+1)'(i);
      end
    end
    grant_sum = {1'b0, last_q} + (IDW+1)'(1) + grant_off;
    if (grant_sum >= (IDW+1)'(NREQ)) begin
      grant_sum = grant_sum - (IDW+1)'(NREQ);
    end
    grant_idx = grant_sum[IDW-1:0];
  end

  // Select the granted requester's block and mode, and raise its ready only in IDLE.
  always_comb begin
    grant_data = '0;
    grant_mode = 1'b0;
    req_ready  = '0;
    for (int c = 0; c < NREQ; c++) begin
      if (grant_idx == IDW'(c)) begin
        grant_data = req_data[64*c +: 64];
        grant_mode = req_mode[c];
      end
      req_ready[c] = (state_q == ST_IDLE) && grant_found && (grant_idx == IDW'(c));
    end
  end

  // Sequencer: accept, one-cycle load, timed core run, then hold the response.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gid_d       = gid_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    pdata_d     = pdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          pdata_d = grant_data;
          mode_d  = grant_mode;
          gid_d   = grant_idx;
          last_d  = grant_idx;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(CORE_LAT)) begin
          rsp_data_d  = core_cdata;
          rsp_id_d    = gid_q;
          rsp_valid_d = 1'b1;
          if (!core_done) begin
            err_d = 1'b1;
          end
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any block in flight without a response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      last_q      <= IDW'(NREQ - 1);
      gid_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      pdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gid_q       <= gid_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      pdata_q     <= pdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  assign core_load  = (state_q == ST_LOAD);
  assign core_mode  = mode_q;
  assign core_pdata = pdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = (state_q != ST_IDLE);
  assign err        = err_q;

endmodule

// File: tb/tb_gost_core_arbiter.sv
// tb_gost_core_arbiter: drives requesters and a stand-in cipher core, and
// checks responses against a queue of expected results from a round-robin
// reference model.
module tb_gost_core_arbiter;

  localparam int NREQ     = 2;
  localparam int IDW      = 1;
  localparam int CORE_LAT = 32;
  localparam logic [63:0] KEY = 64'hA5C3_1E0F_7B29_D486;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_mode;
  logic [64*NREQ-1:0] req_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [63:0]        rsp_data;
  logic               core_load;
  logic               core_mode;
  logic [63:0]        core_pdata;
  logic               core_done;
  logic [63:0]        core_cdata;
  logic               busy;
  logic               err;

  logic               drv_valid [NREQ];
  logic               drv_mode  [NREQ];
  logic [63:0]        drv_data  [NREQ];

  typedef struct {
    logic [IDW-1:0] id;
    logic [63:0]    data;
    logic           err;
  } exp_t;

  exp_t        exp_q[$];
  int          grant_log[$];
  int          checks   = 0;
  int          errors   = 0;
  int          m_last   = NREQ - 1;
  bit          m_busy   = 1'b0;
  bit          m_err    = 1'b0;
  bit          m_seen   = 1'b0;
  int          m_edges  = 0;
  int          mg       = 0;
  logic [63:0] m_pdata  = '0;
  logic        m_mode   = 1'b0;
  logic [NREQ-1:0] m_onehot;
  logic [63:0] last_rsp = '0;
  int          n_rsp    = 0;
  int          n_issued = 0;
  int          rsp_mode = 0;
  bit          spur_early = 1'b0;
  bit          kill_done  = 1'b0;
  int          core_cnt   = -1;
  logic [63:0] core_res   = '0;

  gost_core_arbiter #(.NREQ(NREQ), .IDW(IDW), .CORE_LAT(CORE_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .core_load(core_load), .core_mode(core_mode), .core_pdata(core_pdata),
    .core_done(core_done), .core_cdata(core_cdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Pack the per-requester drive variables onto the DUT buses.
  always_comb begin
    req_valid = '0;
    req_mode  = '0;
    req_data  = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_valid[k]          = drv_valid[k];
      req_mode[k]           = drv_mode[k];
      req_data[64*k +: 64]  = drv_data[k];
    end
  end

  // Stand-in cipher: an invertible keyed rotate, so decrypt undoes encrypt.
  function automatic logic [63:0] cipher(input logic [63:0] x, input logic m);
    logic [63:0] y;
    if (!m) begin
      y = {x[50:0], x[63:51]} ^ KEY;
    end else begin
      y = x ^ KEY;
      y = {y[12:0], y[63:13]};
    end
    return y;
  endfunction

  // Core model: done comes CORE_LAT cycles after it sees load; optional early
  // spurious pulse and optional suppression of the real pulse.
  always @(posedge clk) begin
    if (core_load) begin
      core_cnt <= 0;
      core_res <= cipher(core_pdata, core_mode);
    end else if (core_cnt >= 0 && core_cnt < 40) begin
      core_cnt <= core_cnt + 1;
    end
  end
  assign core_done  = ((core_cnt == CORE_LAT) && !kill_done) || (spur_early && core_cnt == 0);
  assign core_cdata = core_res;

  function automatic void checkOutput(input string name, input logic [63:0] actual,
                                      input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endfunction

  // Reference arbiter: first valid requester after the last grant, wrapping.
  function automatic int model_grant(input logic [NREQ-1:0] v);
    for (int i = 1; i <= NREQ; i++) begin
      if (v[(m_last + i) % NREQ]) return (m_last + i) % NREQ;
    end
    return -1;
  endfunction

  // Monitor: predicts grants, pushes expected results, and checks every output.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      m_busy = 1'b0;
      m_last = NREQ - 1;
      m_err  = 1'b0;
    end else if (!m_busy) begin
      mg = model_grant(req_valid);
      m_onehot = '0;
      if (mg >= 0) m_onehot[mg] = 1'b1;
      checkOutput("idle_req_ready", 64'(req_ready), 64'(m_onehot));
      checkOutput("idle_outputs", 64'({busy, core_load, rsp_valid, err}), 64'({3'b000, m_err}));
      if (mg >= 0) begin
        m_busy  = 1'b1;
        m_edges = -1;
        m_seen  = 1'b0;
        m_last  = mg;
        m_pdata = drv_data[mg];
        m_mode  = drv_mode[mg];
        m_err   = m_err | kill_done;
        exp_q.push_back('{id: IDW'(mg), data: cipher(m_pdata, m_mode), err: m_err});
        grant_log.push_back(mg);
      end
    end else begin
      m_edges++;
      checkOutput("busy_req_ready", 64'(req_ready), 64'(0));
      checkOutput("busy_flag", 64'(busy), 64'(1));
      checkOutput("core_load", 64'(core_load), 64'(m_edges == 0));
      checkOutput("core_inputs", {core_pdata[62:0], core_mode}, {m_pdata[62:0], m_mode});
      if (rsp_valid) begin
        if (!m_seen) begin
          m_seen = 1'b1;
          checkOutput("rsp_latency", 64'(m_edges), 64'(34));
        end
        if (exp_q.size() == 0) begin
          checkOutput("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          checkOutput("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
          checkOutput("rsp_data", rsp_data, exp_q[0].data);
          if (rsp_ready) begin
            checkOutput("rsp_err", 64'(err), 64'(exp_q[0].err));
            void'(exp_q.pop_front());
            last_rsp = rsp_data;
            n_rsp++;
            m_busy = 1'b0;
          end
        end
      end else if (m_edges > 40) begin
        checkOutput("rsp_timeout", 64'(rsp_valid), 64'(1));
        exp_q.delete();
        m_busy = 1'b0;
      end
    end
  end

  // Response consumer: always ready, random ready, or held off.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rsp_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Present one block on requester k and wait (bounded) for its accept.
  task automatic applyStimulus(input int k, input logic [63:0] data, input logic mode,
                               input bit keep);
    bit ok;
    ok = 1'b0;
    drv_valid[k] = 1'b1;
    drv_data[k]  = data;
    drv_mode[k]  = mode;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (req_ready[k]) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("accept_timeout", 64'(ok), 64'(1));
    if (ok) n_issued++;
    @(posedge clk);
    #1;
    if (!keep || !ok) drv_valid[k] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (!m_busy && exp_q.size() == 0 && req_valid == '0) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("idle_timeout", 64'(ok), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic random_requester(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      applyStimulus(k, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  // Directed scenarios followed by a randomized phase.
  initial begin
    int saved;
    logic [63:0] enc;
    for (int k = 0; k < NREQ; k++) begin
      drv_valid[k] = 1'b0;
      drv_mode[k]  = 1'b0;
      drv_data[k]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rsp", {rsp_data[61:0], rsp_valid, rsp_id}, 64'(0));
    checkOutput("reset_core", {core_pdata[61:0], core_load, core_mode}, 64'(0));
    checkOutput("reset_flags", 64'({busy, err, req_ready}), 64'(0));
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single encrypt");
    applyStimulus(0, 64'h0123456789ABCDEF, 1'b0, 1'b0);
    wait_idle();
    checkOutput("single_data", last_rsp, cipher(64'h0123456789ABCDEF, 1'b0));

    $display("[TB] round trip");
    applyStimulus(1, 64'h0123456789ABCDEF, 1'b0, 1'b0);
    wait_idle();
    enc = last_rsp;
    applyStimulus(0, enc, 1'b1, 1'b0);
    wait_idle();
    checkOutput("roundtrip_data", last_rsp, 64'h0123456789ABCDEF);

    $display("[TB] contention");
    pulse_reset();
    grant_log.delete();
    fork
      begin
        applyStimulus(0, 64'h1111_2222_3333_4444, 1'b0, 1'b1);
        applyStimulus(0, 64'h5555_6666_7777_8888, 1'b1, 1'b0);
      end
      begin
        applyStimulus(1, 64'h9999_AAAA_BBBB_CCCC, 1'b1, 1'b1);
        applyStimulus(1, 64'hDDDD_EEEE_FFFF_0000, 1'b0, 1'b0);
      end
    join
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("contention_grant%0d", i),
                  64'((i < grant_log.size()) ? grant_log[i] : 99), 64'(i % 2));
    end

    $display("[TB] backpressure");
    rsp_mode = 2;
    applyStimulus(0, 64'hCAFE_F00D_DEAD_BEEF, 1'b0, 1'b0);
    for (int t = 0; t < 100 && !rsp_valid; t++) @(negedge clk);
    repeat (50) @(negedge clk);
    @(posedge clk);
    #1;
    fork
      applyStimulus(1, 64'h0F0F_F0F0_1234_5678, 1'b1, 1'b0);
      begin
        repeat (5) @(negedge clk);
        rsp_mode = 0;
      end
    join
    wait_idle();

    $display("[TB] spurious done");
    spur_early = 1'b1;
    kill_done  = 1'b1;
    applyStimulus(1, 64'h7777_0000_7777_0000, 1'b0, 1'b0);
    wait_idle();
    spur_early = 1'b0;
    kill_done  = 1'b0;
    checkOutput("err_set", 64'(err), 64'(1));
    applyStimulus(0, 64'h0000_1111_0000_1111, 1'b1, 1'b0);
    wait_idle();
    checkOutput("err_sticky", 64'(err), 64'(1));

    $display("[TB] reset mid-run");
    saved = n_rsp;
    applyStimulus(0, 64'hABCD_EF01_2345_6789, 1'b0, 1'b0);
    repeat (11) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst_rsp", {rsp_data[61:0], rsp_valid, rsp_id}, 64'(0));
    checkOutput("midrst_core", {core_pdata[61:0], core_load, core_mode}, 64'(0));
    checkOutput("midrst_flags", 64'({busy, err, req_ready}), 64'(0));
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    checkOutput("midrst_no_rsp", 64'(n_rsp), 64'(saved));
    applyStimulus(1, 64'h1357_9BDF_2468_ACE0, 1'b1, 1'b0);
    wait_idle();
    checkOutput("after_rst_err", 64'(err), 64'(0));
    checkOutput("after_rst_count", 64'(n_rsp), 64'(saved + 1));

    $display("[TB] random traffic");
    rsp_mode = 1;
    fork
      random_requester(0, 12);
      random_requester(1, 12);
    join
    wait_idle();
    rsp_mode = 0;
    checkOutput("total_responses", 64'(n_rsp), 64'(n_issued - 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound in case a handshake never completes.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
